// File: rtl/fifo_wr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Package  : fifo_arb_pkg
// Brief    : Shared constants, state encoding and helpers for fifo_wr_arbiter.
// Revision : 1.0  initial release
// ============================================================================
package fifo_arb_pkg;

   localparam int   NUM_REQ_MAX   = 8;
   localparam logic ARB_ST_EMPTY  = 1'b0;
   localparam logic ARB_ST_LOADED = 1'b1;

   typedef enum logic {
      ST_EMPTY  = ARB_ST_EMPTY,
      ST_LOADED = ARB_ST_LOADED
   } arb_state_t;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_wr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Interface : fifo_wr_arbiter_if
// Brief     : Producer valid/ready bundle plus FIFO write port of the arbiter.
// Revision  : 1.0  initial release
// ============================================================================
interface fifo_wr_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int DW      = 8,
   parameter int IDW     = 2
);
   logic [NUM_REQ-1:0]    req_valid;
   logic [NUM_REQ*DW-1:0] req_data;
   logic [NUM_REQ-1:0]    req_ready;
   logic                  fifo_full;
   logic                  fifo_wr_en;
   logic [IDW+DW-1:0]     fifo_wr_data;

   modport master (
      input  req_valid, req_data, fifo_full,
      output req_ready, fifo_wr_en, fifo_wr_data
   );

   modport slave (
      output req_valid, req_data, fifo_full,
      input  req_ready, fifo_wr_en, fifo_wr_data
   );
endinterface
`default_nettype wire

// File: rtl/fifo_wr_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational round-robin picker: rotate by ptr, priority-encode, unrotate.
// Revision : 1.0  initial release
// ============================================================================
module rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int IDW     = 2
) (
   input  wire  [NUM_REQ-1:0] req,
   input  wire  [IDW-1:0]     ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IDW-1:0]     idx
);
   logic [NUM_REQ-1:0] w_rot;
   logic [IDW-1:0]     w_off;
   logic               w_hit;

   always_comb begin
      w_rot = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_rot[k] = req[(int'(ptr) + k) % NUM_REQ];
      end

      // Scan downward so the lowest rotated position wins.
      w_off = '0;
      w_hit = 1'b0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (w_rot[k]) begin
            w_off = IDW'(k);
            w_hit = 1'b1;
         end
      end

      idx = IDW'((int'(w_off) + int'(ptr)) % NUM_REQ);
      gnt = w_hit ? (NUM_REQ'(1) << idx) : '0;
   end
endmodule
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_wr_arbiter
// Brief    : Round-robin write arbiter feeding the FIFO through a one-entry tagged
//            output register. Optional per-producer grant counters: FIFO_ARB_STATS_EN.
// Revision : 1.0  initial release
// ============================================================================
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int DW      = 8,
   parameter int IDW     = 2
) (
   input  wire               clk,
   input  wire               rst,
   input  wire               ena,
   fifo_wr_arbiter_if.master bus,
   output logic              idle
`ifdef FIFO_ARB_STATS_EN
   ,
   output logic [NUM_REQ*8-1:0] grant_cnt
`endif
);
   generate
      if (NUM_REQ < 2 || NUM_REQ > NUM_REQ_MAX || IDW < clog2(NUM_REQ)) begin : g_param_check
         $error("fifo_wr_arbiter: illegal NUM_REQ/IDW combination");
      end
   endgenerate

   arb_state_t          r_state;
   arb_state_t          w_state_nxt;
   logic [IDW+DW-1:0]   r_out;
   logic [IDW-1:0]      r_rr_ptr;
   logic [NUM_REQ-1:0]  w_gnt;
   logic [NUM_REQ-1:0]  w_ready;
   logic [IDW-1:0]      w_idx;
   logic [DW-1:0]       w_sel_data;
   logic                w_wr_en;
   logic                w_grant_ok;
   logic                w_xfer;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDW     (IDW)
   ) u_pick (
      .req (bus.req_valid),
      .ptr (r_rr_ptr),
      .gnt (w_gnt),
      .idx (w_idx)
   );

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_EMPTY;
      else     r_state <= w_state_nxt;
   end

   // Reset also masks grants and the strobe so nothing moves while it is held.
   always_comb begin
      w_wr_en     = !rst && (r_state == ST_LOADED) && !bus.fifo_full;
      w_grant_ok  = ena && !rst && ((r_state == ST_EMPTY) || w_wr_en);
      w_ready     = w_grant_ok ? w_gnt : '0;
      w_xfer      = |(bus.req_valid & w_ready);
      w_state_nxt = r_state;
      if (w_xfer)       w_state_nxt = ST_LOADED;
      else if (w_wr_en) w_state_nxt = ST_EMPTY;
   end

   always_comb begin
      w_sel_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_gnt[i]) w_sel_data = bus.req_data[i*DW +: DW];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_out    <= '0;
         r_rr_ptr <= '0;
      end else if (w_xfer) begin
         r_out    <= {w_idx, w_sel_data};
         r_rr_ptr <= (w_idx == IDW'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
      end
   end

   assign bus.req_ready    = w_ready;
   assign bus.fifo_wr_en   = w_wr_en;
   assign bus.fifo_wr_data = r_out;
   assign idle             = rst || ((r_state == ST_EMPTY) && !(|bus.req_valid));

`ifdef FIFO_ARB_STATS_EN
   for (genvar g = 0; g < NUM_REQ; g++) begin : g_stats
      logic [7:0] r_cnt;
      always_ff @(posedge clk) begin
         if (rst)                                   r_cnt <= '0;
         else if (w_xfer && w_gnt[g] && r_cnt != 8'hFF) r_cnt <= r_cnt + 8'd1;
      end
      assign grant_cnt[g*8 +: 8] = r_cnt;
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_wr_arbiter
// Brief    : Directed vector table, corner sequences and random traffic against a
//            queue-based reference for fifo_wr_arbiter.
// Revision : 1.0  initial release
// ============================================================================
module tb_fifo_wr_arbiter;
   localparam int N   = 4;
   localparam int DW  = 8;
   localparam int IDW = 2;

   logic clk = 1'b0;
   logic rst;
   logic ena;
   logic idle;
`ifdef FIFO_ARB_STATS_EN
   logic [N*8-1:0] grant_cnt;
`endif

   fifo_wr_arbiter_if #(.NUM_REQ(N), .DW(DW), .IDW(IDW)) bus ();

   fifo_wr_arbiter #(
      .NUM_REQ (N),
      .DW      (DW),
      .IDW     (IDW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .ena       (ena),
      .bus       (bus),
      .idle      (idle)
`ifdef FIFO_ARB_STATS_EN
      ,
      .grant_cnt (grant_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic              rst;
      logic              ena;
      logic [N-1:0]      valid;
      logic [N*DW-1:0]   data;
      logic              full;
      logic [N-1:0]      ready;
      logic              wr_en;
      logic [IDW+DW-1:0] wr_data;
      logic              idle;
   } vec_t;

   vec_t              tbl[$];
   int                n_vec = 0;
   int                n_err = 0;
   logic [IDW+DW-1:0] m_q[$];
   int                m_ptr = 0;
   int                m_cnt[N] = '{default: 0};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   task automatic add(input logic r, input logic e, input logic [N-1:0] v,
                      input logic [N*DW-1:0] d, input logic f, input logic [N-1:0] rdy,
                      input logic we, input logic [IDW+DW-1:0] wd, input logic idl);
      vec_t x;
      x.rst = r; x.ena = e; x.valid = v; x.data = d; x.full = f;
      x.ready = rdy; x.wr_en = we; x.wr_data = wd; x.idle = idl;
      tbl.push_back(x);
   endtask

   // One clock: drive at negedge, compare before posedge, advance the reference after it.
   task automatic step(input vec_t v, input bit use_tbl);
      logic [N-1:0]      m_rdy, e_rdy;
      logic              m_wr, e_wr, m_idle, e_idle;
      logic [IDW+DW-1:0] m_wd, e_wd;
      int                win;
      @(negedge clk);
      rst           = v.rst;
      ena           = v.ena;
      bus.req_valid = v.valid;
      bus.req_data  = v.data;
      bus.fifo_full = v.full;
      #2;
      m_wr = !v.rst && (m_q.size() != 0) && !v.full;
      win  = -1;
      for (int k = 0; k < N; k++) begin
         if (win < 0 && v.valid[(m_ptr + k) % N]) win = (m_ptr + k) % N;
      end
      m_rdy  = (v.ena && !v.rst && (m_q.size() == 0 || m_wr) && win >= 0) ? N'(1 << win) : '0;
      m_wd   = (m_q.size() != 0) ? m_q[0] : '0;
      m_idle = v.rst || (m_q.size() == 0 && v.valid == '0);
      if (use_tbl) begin
         e_rdy = v.ready; e_wr = v.wr_en; e_wd = v.wr_data; e_idle = v.idle;
      end else begin
         e_rdy = m_rdy; e_wr = m_wr; e_wd = m_wd; e_idle = m_idle;
      end
      chk("req_ready",  32'(bus.req_ready),  32'(e_rdy));
      chk("fifo_wr_en", 32'(bus.fifo_wr_en), 32'(e_wr));
      chk("idle",       32'(idle),           32'(e_idle));
      if (e_wr) chk("fifo_wr_data", 32'(bus.fifo_wr_data), 32'(e_wd));
      @(posedge clk);
      if (v.rst) begin
         m_q.delete();
         m_ptr = 0;
         for (int i = 0; i < N; i++) m_cnt[i] = 0;
      end else begin
         if (m_wr) void'(m_q.pop_front());
         if (m_rdy != '0) begin
            m_q.push_back({IDW'(win), v.data[win*DW +: DW]});
            m_ptr = (win + 1) % N;
            if (m_cnt[win] < 255) m_cnt[win]++;
         end
      end
   endtask

   task automatic drive(input logic r, input logic e, input logic [N-1:0] v,
                        input logic [N*DW-1:0] d, input logic f);
      vec_t x;
      x = '{default: '0};
      x.rst = r; x.ena = e; x.valid = v; x.data = d; x.full = f;
      step(x, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [N*DW-1:0] dd;
      logic [N*DW-1:0] db;
      dd = 32'h44332211;
      db = 32'h0000A500;
      rst = 1'b1; ena = 1'b1;
      bus.req_valid = '1; bus.req_data = '0; bus.fifo_full = 1'b0;

      // rst, ena, valid, data, full | ready, wr_en, wr_data, idle
      add(1, 1, 4'hF, dd, 0, 4'h0, 0, 10'h000, 1);
      add(1, 1, 4'hF, dd, 0, 4'h0, 0, 10'h000, 1);
      add(0, 1, 4'hF, dd, 0, 4'h1, 0, 10'h000, 0);
      add(0, 1, 4'hF, dd, 0, 4'h2, 1, 10'h011, 0);
      add(0, 1, 4'hF, dd, 0, 4'h4, 1, 10'h122, 0);
      add(0, 1, 4'hF, dd, 0, 4'h8, 1, 10'h233, 0);
      add(0, 1, 4'hF, dd, 0, 4'h1, 1, 10'h344, 0);
      add(0, 1, 4'h0, dd, 0, 4'h0, 1, 10'h011, 0);
      add(0, 1, 4'h0, dd, 0, 4'h0, 0, 10'h000, 1);
      add(0, 1, 4'h2, db, 0, 4'h2, 0, 10'h000, 0);
      for (int i = 0; i < 5; i++) add(0, 1, 4'hF, db, 1, 4'h0, 0, 10'h000, 0);
      add(0, 1, 4'h0, db, 0, 4'h0, 1, 10'h1A5, 0);
      add(0, 1, 4'h0, db, 0, 4'h0, 0, 10'h000, 1);
      add(0, 1, 4'h4, dd, 0, 4'h4, 0, 10'h000, 0);
      add(0, 1, 4'h9, dd, 0, 4'h8, 1, 10'h233, 0);
      add(0, 1, 4'h9, dd, 0, 4'h1, 1, 10'h344, 0);
      add(0, 1, 4'h9, dd, 0, 4'h8, 1, 10'h011, 0);
      add(0, 1, 4'h9, dd, 0, 4'h1, 1, 10'h344, 0);
      add(0, 0, 4'h9, dd, 0, 4'h0, 1, 10'h011, 0);
      add(0, 0, 4'h9, dd, 0, 4'h0, 0, 10'h000, 0);
      add(0, 0, 4'h0, dd, 0, 4'h0, 0, 10'h000, 1);

      for (int i = 0; i < tbl.size(); i++) step(tbl[i], 1'b1);

      // Reset while loaded discards the word.
      drive(0, 1, 4'h1, 32'hDEADBEEF, 0);
      drive(1, 1, 4'h1, 32'hDEADBEEF, 0);
      drive(0, 1, 4'h0, 32'hDEADBEEF, 0);
      drive(0, 1, 4'h0, 32'hDEADBEEF, 0);

      // Single requester is granted back to back.
      for (int i = 0; i < 4; i++) drive(0, 1, 4'h4, $urandom(), 0);
      drive(0, 1, 4'h0, 32'h0, 0);

      // FIFO full while ena is low, then release.
      drive(0, 1, 4'h8, 32'h5A000000, 0);
      drive(0, 0, 4'hF, 32'h12345678, 1);
      drive(0, 0, 4'hF, 32'h12345678, 1);
      drive(0, 0, 4'hF, 32'h12345678, 0);
      drive(0, 0, 4'h0, 32'h12345678, 0);

      for (int i = 0; i < 500; i++) begin
         drive($urandom_range(0, 63) == 0, $urandom_range(0, 7) != 0,
               4'($urandom_range(0, 15)), $urandom(), $urandom_range(0, 2) == 0);
      end

`ifdef FIFO_ARB_STATS_EN
      drive(1, 1, 4'h0, 32'h0, 0);
      for (int i = 0; i < 300; i++) drive(0, 1, 4'h4, $urandom(), 0);
      @(negedge clk);
      chk("grant_cnt2_sat", 32'(grant_cnt[2*8 +: 8]), 32'd255);
      for (int i = 0; i < N; i++) chk("grant_cnt", 32'(grant_cnt[i*8 +: 8]), 32'(m_cnt[i]));
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
`default_nettype wire
